// File: rtl/axis_sink_checker.sv
// AXI-Stream sink with programmable back-pressure, beat/packet statistics and
// an incrementing-word sequence checker on the low 32 bits of each beat.
module axis_sink_checker #(
  parameter int STREAM_WIDTH = 512,
  parameter int CNT_WIDTH    = 32,
  parameter int THR_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [THR_WIDTH-1:0]    throttle,
  input  logic [STREAM_WIDTH-1:0] AXIS_RX_TDATA,
  input  logic                    AXIS_RX_TVALID,
  input  logic                    AXIS_RX_TLAST,
  output logic                    AXIS_RX_TREADY,
  output logic [STREAM_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    packet_count,
  output logic [CNT_WIDTH-1:0]    error_count,
  output logic [CNT_WIDTH-1:0]    last_pkt_len,
  output logic                    in_packet
);

  // state    | meaning
  // READY    | TREADY may be asserted, beats accepted
  // STALL    | idle gap after a throttled beat, stall_q cycles remain
  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [THR_WIDTH-1:0] THR_ONE = {{(THR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]              state_q, state_d;
  logic [THR_WIDTH-1:0]    stall_q, stall_d;
  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0]    pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]    err_q, err_d;
  logic [CNT_WIDTH-1:0]    plen_q, plen_d;
  logic [CNT_WIDTH-1:0]    len_q, len_d;
  logic [31:0]             exp_q, exp_d;
  logic                    inp_q, inp_d;
  logic                    tready;
  logic                    accept;

  assign tready = resetn & enable & ~clear & (state_q == ST_READY);
  assign accept = AXIS_RX_TVALID & tready;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    data_d  = data_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    plen_d  = plen_q;
    len_d   = len_q;
    exp_d   = exp_q;
    inp_d   = inp_q;
    if (clear) begin
      state_d = ST_READY;
      stall_d = '0;
      beat_d  = '0;
      pkt_d   = '0;
      err_d   = '0;
      plen_d  = '0;
      len_d   = '0;
      exp_d   = '0;
      inp_d   = 1'b0;
    end else begin
      // The stall gap runs down even while enable is low.
      if (state_q == ST_STALL) begin
        stall_d = stall_q - THR_ONE;
        if (stall_q <= THR_ONE) state_d = ST_READY;
      end
      if (accept) begin
        data_d = AXIS_RX_TDATA;
        beat_d = beat_q + CNT_ONE;
        if (AXIS_RX_TDATA[31:0] != exp_q && err_q != '1) err_d = err_q + CNT_ONE;
        exp_d = AXIS_RX_TDATA[31:0] + 32'd1;
        if (AXIS_RX_TLAST) begin
          pkt_d  = pkt_q + CNT_ONE;
          plen_d = len_q + CNT_ONE;
          len_d  = '0;
          inp_d  = 1'b0;
        end else begin
          len_d = len_q + CNT_ONE;
          inp_d = 1'b1;
        end
        if (throttle != '0) begin
          state_d = ST_STALL;
          stall_d = throttle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_READY;
      stall_q <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
      plen_q  <= '0;
      len_q   <= '0;
      exp_q   <= '0;
      inp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      plen_q  <= plen_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      inp_q   <= inp_d;
    end
  end

  assign AXIS_RX_TREADY = tready;
  assign data           = data_q;
  assign beat_count     = beat_q;
  assign packet_count   = pkt_q;
  assign error_count    = err_q;
  assign last_pkt_len   = plen_q;
  assign in_packet      = inp_q;

endmodule

// File: tb/tb_axis_sink_checker.sv
// Directed bench for axis_sink_checker: a vector table for single-cycle
// behaviour plus hand sequences for throttling, reset, clear and saturation.
module tb_axis_sink_checker;

  logic        clk = 1'b0;
  logic        resetn, enable, clear, tvalid, tlast;
  logic [3:0]  throttle;
  logic [63:0] tdata;

  logic        tready, inp;
  logic [63:0] data;
  logic [31:0] bc, pc, ec, pl;

  logic        tready1, inp1;
  logic [63:0] data1;
  logic [3:0]  bc1, pc1, ec1, pl1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_sink_checker #(.STREAM_WIDTH(64), .CNT_WIDTH(32), .THR_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear), .throttle(throttle),
    .AXIS_RX_TDATA(tdata), .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast),
    .AXIS_RX_TREADY(tready), .data(data), .beat_count(bc), .packet_count(pc),
    .error_count(ec), .last_pkt_len(pl), .in_packet(inp)
  );

  axis_sink_checker #(.STREAM_WIDTH(64), .CNT_WIDTH(4), .THR_WIDTH(4)) dut_small (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear), .throttle(throttle),
    .AXIS_RX_TDATA(tdata), .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast),
    .AXIS_RX_TREADY(tready1), .data(data1), .beat_count(bc1), .packet_count(pc1),
    .error_count(ec1), .last_pkt_len(pl1), .in_packet(inp1)
  );

  typedef struct {
    logic        en, clr, vld, lst;
    logic [3:0]  thr;
    logic [31:0] word;
    logic        rdy;
    int          beats, pkts, errs, plen;
    logic        inp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, clr, vld, lst, input logic [3:0] thr,
                              input logic [31:0] word, input logic rdy,
                              input int beats, pkts, errs, plen, input logic inp_e);
    vec_t v;
    v.en = en; v.clr = clr; v.vld = vld; v.lst = lst; v.thr = thr; v.word = word;
    v.rdy = rdy; v.beats = beats; v.pkts = pkts; v.errs = errs; v.plen = plen;
    v.inp = inp_e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, clr, vld, lst, input logic [3:0] thr,
                       input logic [31:0] w);
    enable = en; clear = clr; tvalid = vld; tlast = lst; throttle = thr;
    tdata = {~w, w};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input int beats, pkts, errs, plen,
                           input logic inp_e);
    chk({tag, ".beats"}, {32'd0, bc}, beats);
    chk({tag, ".pkts"},  {32'd0, pc}, pkts);
    chk({tag, ".errs"},  {32'd0, ec}, errs);
    chk({tag, ".plen"},  {32'd0, pl}, plen);
    chk({tag, ".inp"},   {63'd0, inp}, {63'd0, inp_e});
  endtask

  logic [63:0] exp_data;

  initial begin
    resetn = 1'b0;
    drive(1, 0, 1, 0, 0, 32'd0);
    exp_data = '0;

    // 8-beat full-rate packet
    for (int i = 0; i < 8; i++)
      add(1, 0, 1, i == 7, 0, i, 1, i + 1, i == 7 ? 1 : 0, 0, i == 7 ? 8 : 0, i != 7);
    // clear, then sequence 0,1,(enable low),(idle),5,6 with one resync error
    add(1, 1, 1, 0, 0, 32'd8, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 32'd0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 32'd1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 32'd5, 0, 2, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 32'd5, 1, 2, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 32'd5, 1, 3, 0, 1, 0, 1);
    add(1, 0, 1, 1, 0, 32'd6, 1, 4, 1, 1, 4, 0);
    // 0xFFFFFFFF mismatches exp=7, then wraps cleanly to 0
    add(1, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 5, 1, 2, 4, 1);
    add(1, 0, 1, 1, 0, 32'd0, 1, 6, 2, 2, 2, 0);
    // single-beat packet
    add(1, 0, 1, 1, 0, 32'd1, 1, 7, 3, 2, 1, 0);

    repeat (2) tick();
    @(negedge clk);
    chk("rst.tready", {63'd0, tready}, 64'd0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    chk("rst.data", data, 64'd0);

    @(posedge clk);
    #1;
    resetn = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].lst, tbl[i].thr, tbl[i].word);
      @(negedge clk);
      chk($sformatf("v%0d.tready", i), {63'd0, tready}, {63'd0, tbl[i].rdy});
      tick();
      if (tbl[i].rdy && tbl[i].vld) exp_data = {~tbl[i].word, tbl[i].word};
      chk_stats($sformatf("v%0d", i), tbl[i].beats, tbl[i].pkts, tbl[i].errs,
                tbl[i].plen, tbl[i].inp);
      chk($sformatf("v%0d.data", i), data, exp_data);
    end

    // throttle=3: TREADY 1,0,0,0; throttle changes during stall are ignored
    drive(1, 1, 0, 0, 0, 32'd0);
    tick();
    for (int c = 0; c < 16; c++) begin
      drive(1, 0, 1, 0, (c % 4 == 0) ? 4'd3 : 4'd0, c / 4);
      @(negedge clk);
      chk($sformatf("thr.c%0d.tready", c), {63'd0, tready}, {63'd0, c % 4 == 0});
      tick();
    end
    chk_stats("thr", 4, 0, 0, 0, 1);

    // reset asserted while stalled mid-packet
    drive(1, 0, 1, 0, 3, 32'd4);
    tick();
    chk("stall.beats", {32'd0, bc}, 64'd5);
    resetn = 1'b0;
    @(negedge clk);
    chk("rststall.tready_comb", {63'd0, tready}, 64'd0);
    tick();
    @(negedge clk);
    chk("rststall.tready", {63'd0, tready}, 64'd0);
    chk_stats("rststall", 0, 0, 0, 0, 0);
    chk("rststall.data", data, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1, 0, 1, 0, 0, 32'd0);
    @(negedge clk);
    chk("rel.tready", {63'd0, tready}, 64'd1);
    chk("rel.inp", {63'd0, inp}, 64'd0);
    tick();
    chk("rel.beats", {32'd0, bc}, 64'd1);

    // three beats in, clear, then a TLAST beat with word 0
    drive(1, 0, 1, 0, 0, 32'd1);
    tick();
    drive(1, 0, 1, 0, 0, 32'd2);
    tick();
    chk_stats("pre_clr", 3, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 32'd3);
    @(negedge clk);
    chk("clr.tready", {63'd0, tready}, 64'd0);
    tick();
    chk_stats("clr", 0, 0, 0, 0, 0);
    chk("clr.data", data, {~32'd2, 32'd2});
    drive(1, 0, 1, 1, 0, 32'd0);
    tick();
    chk_stats("post_clr", 1, 1, 0, 1, 0);

    // error_count saturation on the 4-bit build
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 1, 0, 0, 32'd5);
      tick();
    end
    chk("sat.ec16", {60'd0, ec1}, 64'hF);
    drive(1, 0, 1, 0, 0, 32'd5);
    tick();
    chk("sat.ec17", {60'd0, ec1}, 64'hF);
    chk("sat.bc17", {60'd0, bc1}, 64'd1);
    chk("sat.wide_ec", {32'd0, ec}, 64'd17);
    drive(0, 0, 0, 0, 0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
